// File: rtl/ip_rewrite_manager_pkg.sv
// Shared types for the IP rewrite manager: request width, status codes,
// tile selector and the update sequencer state encoding.
package ip_rewrite_manager_pkg;

  localparam int IP_REWRITE_TABLE_REQ_BYTES = 16;
  localparam int IP_REWRITE_TABLE_REQ_W     = IP_REWRITE_TABLE_REQ_BYTES * 8;

  typedef enum logic [7:0] {
    IP_REWRITE_OK  = 8'h00,
    IP_REWRITE_BAD = 8'h01
  } ip_rewrite_status;

  typedef enum logic [0:0] {
    TILE_RX = 1'b0,
    TILE_TX = 1'b1
  } ip_manager_tile_sel;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEND_RX = 3'd1,
    WAIT_RX = 3'd2,
    SEND_TX = 3'd3,
    WAIT_TX = 3'd4,
    RESP    = 3'd5
  } seq_state_e;

endpackage

// File: rtl/ip_rewrite_ack_timer.sv
// Saturating ack-wait counter shared by both tile waits; timeout fires on the
// last allowed cycle unless an ack arrives in that same cycle.
module ip_rewrite_ack_timer #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TIMEOUT_W      = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic run,
  input  logic ack,
  output logic timeout
);

  localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= '0;
    end else if (run && (cnt != LAST)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign timeout = run && !ack && (cnt == LAST);

endmodule

// File: rtl/ip_rewrite_update_sequencer.sv
// Programs RX then TX rewrite tile per request, one status per request; notif sends
// stall on backpressure, ack waits time out. `IP_REWRITE_SEQ_STATS_EN adds counters.
module ip_rewrite_update_sequencer
  import ip_rewrite_manager_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TIMEOUT_W      = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              req_val,
  input  logic [IP_REWRITE_TABLE_REQ_W-1:0] req_data,
  output logic                              req_rdy,
  output logic                              rx_notif_val,
  output logic [IP_REWRITE_TABLE_REQ_W-1:0] rx_notif_data,
  input  logic                              rx_notif_rdy,
  input  logic                              rx_ack_val,
  input  logic                              rx_ack_bad,
  output logic                              tx_notif_val,
  output logic [IP_REWRITE_TABLE_REQ_W-1:0] tx_notif_data,
  input  logic                              tx_notif_rdy,
  input  logic                              tx_ack_val,
  input  logic                              tx_ack_bad,
  output logic                              resp_val,
  output logic [7:0]                        resp_status,
  input  logic                              resp_rdy,
  output logic                              busy
`ifdef IP_REWRITE_SEQ_STATS_EN
  ,
  output logic [31:0]                       stat_ok_cnt,
  output logic [31:0]                       stat_bad_cnt,
  output logic [31:0]                       stat_timeout_cnt
`endif
);

  localparam logic [2:0] ST_IDLE    = IDLE;
  localparam logic [2:0] ST_SEND_RX = SEND_RX;
  localparam logic [2:0] ST_WAIT_RX = WAIT_RX;
  localparam logic [2:0] ST_SEND_TX = SEND_TX;
  localparam logic [2:0] ST_WAIT_TX = WAIT_TX;
  localparam logic [2:0] ST_RESP    = RESP;

  logic [2:0]                        state;
  logic [IP_REWRITE_TABLE_REQ_W-1:0] req_q;
  logic [7:0]                        status_q;
  ip_manager_tile_sel                tile_sel;
  logic                              ack_val;
  logic                              timer_start;
  logic                              timer_run;
  logic                              timeout;

  // Only the ack of the tile currently being waited on is ever looked at.
  assign tile_sel    = (state == ST_WAIT_TX) ? TILE_TX : TILE_RX;
  assign ack_val     = (tile_sel == TILE_TX) ? tx_ack_val : rx_ack_val;
  assign timer_run   = (state == ST_WAIT_RX) || (state == ST_WAIT_TX);
  assign timer_start = ((state == ST_SEND_RX) && rx_notif_rdy) ||
                       ((state == ST_SEND_TX) && tx_notif_rdy);

  ip_rewrite_ack_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TIMEOUT_W     (TIMEOUT_W)
  ) u_ack_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (timer_start),
    .run    (timer_run),
    .ack    (ack_val),
    .timeout(timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      req_q    <= '0;
      status_q <= IP_REWRITE_OK;
    end else begin
      case (state)
        ST_IDLE: if (req_val) begin
          req_q <= req_data;
          state <= ST_SEND_RX;
        end
        ST_SEND_RX: if (rx_notif_rdy) state <= ST_WAIT_RX;
        ST_WAIT_RX: begin
          if (rx_ack_val) begin
            if (rx_ack_bad) begin
              status_q <= IP_REWRITE_BAD;
              state    <= ST_RESP;
            end else begin
              state <= ST_SEND_TX;
            end
          end else if (timeout) begin
            status_q <= IP_REWRITE_BAD;
            state    <= ST_RESP;
          end
        end
        ST_SEND_TX: if (tx_notif_rdy) state <= ST_WAIT_TX;
        ST_WAIT_TX: begin
          if (tx_ack_val) begin
            if (tx_ack_bad) status_q <= IP_REWRITE_BAD;
            state <= ST_RESP;
          end else if (timeout) begin
            status_q <= IP_REWRITE_BAD;
            state    <= ST_RESP;
          end
        end
        ST_RESP: if (resp_rdy) begin
          status_q <= IP_REWRITE_OK;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign req_rdy       = (state == ST_IDLE);
  assign busy          = (state != ST_IDLE);
  assign rx_notif_val  = (state == ST_SEND_RX);
  assign tx_notif_val  = (state == ST_SEND_TX);
  assign rx_notif_data = req_q;
  assign tx_notif_data = req_q;
  assign resp_val      = (state == ST_RESP);
  assign resp_status   = status_q;

`ifdef IP_REWRITE_SEQ_STATS_EN
  logic resp_fire;
  assign resp_fire = (state == ST_RESP) && resp_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ok_cnt      <= '0;
      stat_bad_cnt     <= '0;
      stat_timeout_cnt <= '0;
    end else begin
      if (resp_fire && (status_q == IP_REWRITE_OK) && (stat_ok_cnt != '1))
        stat_ok_cnt <= stat_ok_cnt + 1'b1;
      if (resp_fire && (status_q != IP_REWRITE_OK) && (stat_bad_cnt != '1))
        stat_bad_cnt <= stat_bad_cnt + 1'b1;
      if (timeout && (stat_timeout_cnt != '1))
        stat_timeout_cnt <= stat_timeout_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ip_rewrite_update_sequencer.sv
// Directed + randomized bench for ip_rewrite_update_sequencer with a
// transaction-level outcome model (ack window, bad flag, timeout).
module tb_ip_rewrite_update_sequencer;
  import ip_rewrite_manager_pkg::*;

  localparam int TO = 16;
  localparam int W  = IP_REWRITE_TABLE_REQ_W;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_val;
  logic [W-1:0] req_data;
  logic         req_rdy;
  logic         rx_notif_val, rx_notif_rdy, rx_ack_val, rx_ack_bad;
  logic [W-1:0] rx_notif_data;
  logic         tx_notif_val, tx_notif_rdy, tx_ack_val, tx_ack_bad;
  logic [W-1:0] tx_notif_data;
  logic         resp_val, resp_rdy, busy;
  logic [7:0]   resp_status;
`ifdef IP_REWRITE_SEQ_STATS_EN
  logic [31:0]  stat_ok_cnt, stat_bad_cnt, stat_timeout_cnt;
`endif

  int checks = 0;
  int passed = 0;
  int exp_ok = 0, exp_bad = 0, exp_to = 0;

  always #5 clk = ~clk;

  ip_rewrite_update_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_val(req_val), .req_data(req_data), .req_rdy(req_rdy),
    .rx_notif_val(rx_notif_val), .rx_notif_data(rx_notif_data), .rx_notif_rdy(rx_notif_rdy),
    .rx_ack_val(rx_ack_val), .rx_ack_bad(rx_ack_bad),
    .tx_notif_val(tx_notif_val), .tx_notif_data(tx_notif_data), .tx_notif_rdy(tx_notif_rdy),
    .tx_ack_val(tx_ack_val), .tx_ack_bad(tx_ack_bad),
    .resp_val(resp_val), .resp_status(resp_status), .resp_rdy(resp_rdy),
    .busy(busy)
`ifdef IP_REWRITE_SEQ_STATS_EN
    ,
    .stat_ok_cnt(stat_ok_cnt), .stat_bad_cnt(stat_bad_cnt), .stat_timeout_cnt(stat_timeout_cnt)
`endif
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
  endtask

  task automatic chkv(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rand_req();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk_stats();
`ifdef IP_REWRITE_SEQ_STATS_EN
    chkv("stat_ok_cnt", W'(stat_ok_cnt), W'(exp_ok));
    chkv("stat_bad_cnt", W'(stat_bad_cnt), W'(exp_bad));
    chkv("stat_timeout_cnt", W'(stat_timeout_cnt), W'(exp_to));
`endif
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk1({tag, "_req_rdy"}, req_rdy, 1'b1);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_rx_notif_val"}, rx_notif_val, 1'b0);
    chk1({tag, "_tx_notif_val"}, tx_notif_val, 1'b0);
    chk1({tag, "_resp_val"}, resp_val, 1'b0);
    chkv({tag, "_resp_status"}, W'(resp_status), W'(8'h00));
    chkv({tag, "_rx_notif_data"}, rx_notif_data, '0);
    chkv({tag, "_tx_notif_data"}, tx_notif_data, '0);
  endtask

  task automatic send_req(input logic [W-1:0] d);
    int n = 0;
    while (req_rdy !== 1'b1 && n < 8) begin step(); n++; end
    chk1("req_rdy_before_req", req_rdy, 1'b1);
    req_val = 1'b1; req_data = d;
    step();
    req_val = 1'b0; req_data = '0;
    chk1("rx_notif_after_accept", rx_notif_val, 1'b1);
    chk1("busy_after_accept", busy, 1'b1);
  endtask

  task automatic notif_phase(input bit tx, input logic [W-1:0] d, input int hold, input bit poke);
    for (int i = 0; i < hold; i++) begin
      if (poke) begin req_val = 1'b1; req_data = ~d; end
      step();
      chk1("notif_val_held", tx ? tx_notif_val : rx_notif_val, 1'b1);
      chkv("notif_data_held", tx ? tx_notif_data : rx_notif_data, d);
      chk1("req_rdy_low_in_send", req_rdy, 1'b0);
    end
    req_val = 1'b0; req_data = '0;
    chkv("notif_data", tx ? tx_notif_data : rx_notif_data, d);
    if (tx) tx_notif_rdy = 1'b1; else rx_notif_rdy = 1'b1;
    step();
    tx_notif_rdy = 1'b0; rx_notif_rdy = 1'b0;
    chk1("notif_val_drop", tx ? tx_notif_val : rx_notif_val, 1'b0);
  endtask

  // Model: an ack in wait-cycle index 0..TO-1 is honoured; none in that window is a timeout.
  task automatic wait_phase(input bit tx, input int delay, input bit bad, output bit ok);
    bit honoured;
    honoured = (delay >= 0) && (delay < TO);
    ok = honoured && !bad;
    if (!honoured) exp_to++;
    for (int c = 0; c < TO; c++) begin
      if (c == delay) begin
        if (tx) begin tx_ack_val = 1'b1; tx_ack_bad = bad; end
        else begin rx_ack_val = 1'b1; rx_ack_bad = bad; end
      end else if ($urandom_range(0, 3) == 0) begin
        if (tx) begin rx_ack_val = 1'b1; rx_ack_bad = 1'($urandom_range(0, 1)); end
        else begin tx_ack_val = 1'b1; tx_ack_bad = 1'($urandom_range(0, 1)); end
      end
      step();
      rx_ack_val = 1'b0; rx_ack_bad = 1'b0; tx_ack_val = 1'b0; tx_ack_bad = 1'b0;
      if (c == delay) break;
      if (c < TO - 1) begin
        chk1("waiting_no_resp", resp_val, 1'b0);
        chk1("waiting_no_tx_notif", tx_notif_val, 1'b0);
        chk1("waiting_busy", busy, 1'b1);
      end
    end
    if (ok && !tx) begin
      chk1("tx_notif_after_rx_ok", tx_notif_val, 1'b1);
      chk1("no_resp_after_rx_ok", resp_val, 1'b0);
    end else begin
      chk1("resp_after_wait", resp_val, 1'b1);
      chk1("no_tx_notif_at_resp", tx_notif_val, 1'b0);
    end
  endtask

  task automatic resp_phase(input logic [7:0] exp, input int hold, input bit poke);
    chkv("resp_status", W'(resp_status), W'(exp));
    for (int i = 0; i < hold; i++) begin
      if (poke) begin req_val = 1'b1; req_data = rand_req(); end
      step();
      chk1("resp_val_held", resp_val, 1'b1);
      chkv("resp_status_held", W'(resp_status), W'(exp));
      chk1("req_rdy_low_in_resp", req_rdy, 1'b0);
    end
    req_val = 1'b0; req_data = '0;
    resp_rdy = 1'b1;
    step();
    resp_rdy = 1'b0;
    if (exp == 8'h00) exp_ok++; else exp_bad++;
    chk1("resp_val_drop", resp_val, 1'b0);
    chk1("req_rdy_after_resp", req_rdy, 1'b1);
    chkv("status_back_ok", W'(resp_status), W'(8'h00));
    chk_stats();
  endtask

  task automatic txn(input logic [W-1:0] d, input int rxh, input int rxd, input bit rxb,
                     input int txh, input int txd, input bit txb, input int rh, input bit poke);
    bit ok;
    send_req(d);
    notif_phase(1'b0, d, rxh, poke);
    wait_phase(1'b0, rxd, rxb, ok);
    if (ok) begin
      notif_phase(1'b1, d, txh, poke);
      wait_phase(1'b1, txd, txb, ok);
    end
    resp_phase(ok ? 8'h00 : 8'h01, rh, poke);
  endtask

  initial begin
    bit ok;
    logic [W-1:0] d;
    int r1, r2;
    rst_n = 1'b0; req_val = 1'b0; req_data = '0;
    rx_notif_rdy = 1'b0; rx_ack_val = 1'b0; rx_ack_bad = 1'b0;
    tx_notif_rdy = 1'b0; tx_ack_val = 1'b0; tx_ack_bad = 1'b0;
    resp_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    step();
    chk_reset_outputs("post_reset_idle");
    chk_stats();

    // Nominal, RX failure, TX timeout, RX/TX ack-timeout collisions, RX timeout.
    txn(rand_req(), 0, 1, 1'b0, 0, 1, 1'b0, 0, 1'b0);
    txn(rand_req(), 0, 1, 1'b1, 0, 0, 1'b0, 0, 1'b0);
    txn(rand_req(), 0, 0, 1'b0, 0, -1, 1'b0, 0, 1'b0);
    txn(rand_req(), 0, TO - 1, 1'b0, 0, 0, 1'b0, 0, 1'b0);
    txn(rand_req(), 0, 0, 1'b0, 0, TO - 1, 1'b0, 0, 1'b0);
    txn(rand_req(), 0, -1, 1'b0, 0, 0, 1'b0, 0, 1'b0);
    // Long backpressure with a competing request held on req_val.
    txn(rand_req(), 50, 2, 1'b0, 3, 1, 1'b0, 10, 1'b1);

    // Reset while waiting for the TX ack.
    d = rand_req();
    send_req(d);
    notif_phase(1'b0, d, 0, 1'b0);
    wait_phase(1'b0, 0, 1'b0, ok);
    notif_phase(1'b1, d, 0, 1'b0);
    step(); step();
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    exp_ok = 0; exp_bad = 0; exp_to = 0;
    chk_stats();
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk1("no_stale_resp", resp_val, 1'b0);
    end
    txn(rand_req(), 0, 1, 1'b0, 0, 1, 1'b0, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      r1 = $urandom_range(0, 19);
      r2 = $urandom_range(0, 19);
      txn(rand_req(), $urandom_range(0, 3), (r1 >= TO) ? -1 : r1, ($urandom_range(0, 4) == 0),
          $urandom_range(0, 3), (r2 >= TO) ? -1 : r2, ($urandom_range(0, 4) == 0),
          $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ip_rewrite_update_sequencer.md
Name: ip_rewrite_update_sequencer

Overview:
Sequences IP rewrite table updates issued by the manager to the two rewrite tiles. Accepts one ip_rewrite_table_req at a time and programs the RX_REWRITE tile first, then the TX_REWRITE tile. Waits for each tile's ack, with a timeout on each wait. Returns one ip_rewrite_status (OK/BAD) per request. Sits between the manager's NoC request deserializer and the per-tile rewrite notification senders.

Parameters:
TIMEOUT_CYCLES, 1024, max cycles waiting for one tile's ack before declaring BAD (>=2)
TIMEOUT_W, $clog2(TIMEOUT_CYCLES+1), timeout counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_val  in  1  update request valid
req_data  in  IP_REWRITE_TABLE_REQ_BYTES*8  ip_rewrite_table_req
req_rdy  out  1  request accepted when val&rdy
rx_notif_val  out  1  notification to RX rewrite tile
rx_notif_data  out  IP_REWRITE_TABLE_REQ_BYTES*8  latched request
rx_notif_rdy  in  1  RX tile accepts notification
rx_ack_val  in  1  RX tile ack
rx_ack_bad  in  1  RX tile reports failure, qualified by rx_ack_val
tx_notif_val  out  1  notification to TX rewrite tile
tx_notif_data  out  IP_REWRITE_TABLE_REQ_BYTES*8  latched request
tx_notif_rdy  in  1  TX tile accepts notification
tx_ack_val  in  1  TX tile ack
tx_ack_bad  in  1  TX tile failure, qualified by tx_ack_val
resp_val  out  1  response valid
resp_status  out  8  ip_rewrite_status
resp_rdy  in  1  response consumer ready
busy  out  1  state != IDLE

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset: state=IDLE, req_rdy=1, all *_val=0, resp_status=OK, timeout counter=0, latched request=0.
- States and transitions:
  - IDLE: req_rdy=1. On req_val, latch req_data and go to SEND_RX next cycle (1-cycle accept latency).
  - SEND_RX: rx_notif_val=1. Hold rx_notif_data stable until rx_notif_rdy. On handshake go to WAIT_RX and clear the counter.
  - WAIT_RX: count each cycle.
    - rx_ack_val & !rx_ack_bad: go to SEND_TX.
    - rx_ack_val & rx_ack_bad: set status=BAD and go to RESP. TX is skipped, so there is no partial TX programming after an RX failure.
    - Counter reaches TIMEOUT_CYCLES-1 with no ack: status=BAD, go to RESP.
    - An ack in the same cycle the timeout fires takes priority (the ack is honoured).
  - SEND_TX and WAIT_TX: identical to SEND_RX and WAIT_RX using the tx_* ports. Ack OK leads to RESP with status=OK.
  - RESP: resp_val=1 with resp_status held until resp_rdy. On handshake, reset status to OK and return to IDLE. req_rdy goes high the cycle after.
- Ack handling:
  - Acks arriving in any state other than the matching WAIT are dropped and have no effect.
  - Ack ready is implicit (always accepted).
- The notification send phase has no timeout; backpressure there stalls indefinitely.
- Counter width is TIMEOUT_W, saturating, with no wrap.
- rst_n assertion mid-sequence aborts immediately: no response is emitted and every output returns to its reset value asynchronously.
- Minimum request-to-response time with immediate rdy/acks: 6 cycles.

Optional Feature:
IP_REWRITE_SEQ_STATS_EN:
- Defined: adds three 32-bit saturating counters exposed as outputs stat_ok_cnt, stat_bad_cnt and stat_timeout_cnt.
  - stat_ok_cnt and stat_bad_cnt increment on each RESP handshake, by status.
  - stat_timeout_cnt increments on each timeout event.
  - All three clear on reset.
- Undefined: the ports and logic are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package ip_rewrite_manager_pkg gains:
  - a seq_state_e enum: IDLE, SEND_RX, WAIT_RX, SEND_TX, WAIT_TX, RESP;
  - localparam IP_REWRITE_TABLE_REQ_W = IP_REWRITE_TABLE_REQ_BYTES*8.
- Reuse the existing ip_rewrite_status and ip_manager_tile_sel.
- One sub-module is natural: ip_rewrite_ack_timer. It holds the counter, takes a start/clear input and an ack input, and outputs timeout. It is instantiated once and shared across WAIT_RX and WAIT_TX.

Test Plan:
- Nominal: request with all rdy=1; RX ack OK at +2, TX ack OK at +2 -> both notifications carry identical data; resp_status=0x00; request accepted again the next cycle.
- RX failure: rx_ack_bad=1 -> tx_notif_val never asserts; resp_status=0x01.
- TX timeout, TIMEOUT_CYCLES=16: no tx ack -> resp_val rises 16 cycles after the TX handshake; status=0x01; stat_timeout_cnt=1 when IP_REWRITE_SEQ_STATS_EN is defined.
- Ack/timeout collision: rx_ack_val OK exactly in the cycle the counter hits 15 -> proceeds to SEND_TX; final status=0x00.
- Backpressure: rx_notif_rdy=0 for 50 cycles, then resp_rdy=0 for 10 cycles -> data held stable; no timeout; req_rdy=0 throughout; a second req_val is not accepted until after the resp handshake.
- Reset mid-WAIT_TX: drop rst_n -> all val signals 0 immediately; after release, a new request completes with OK and no stale response appears.
